// File: rtl/pipe_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, data-memory freeze,
// branch flushes and halt, with saturating stall/flush counters and a memory-timeout flag.
module pipe_stall_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt_addr,
    input  logic [4:0]       IF_ID_Rs_addr,
    input  logic [4:0]       IF_ID_Rt_addr,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             EX_MEM_mem_req,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout,
    output logic             halted
);
    // state    | meaning
    // RUN      | normal issue; load-use, branch and halt rules apply
    // MEM_WAIT | data memory access outstanding, whole pipe frozen
    // HALTED   | halt retired; PC held, IF/ID fed NOPs until rst
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state, state_next;
    logic             freeze, load_use, flush_event;
    logic [CNT_W-1:0] wait_cnt;

    assign freeze   = EX_MEM_mem_req & ~dmem_ready;
    assign load_use = ID_EX_MemRead & (ID_EX_Rt_addr != 5'd0) &
                      ((ID_EX_Rt_addr == IF_ID_Rs_addr) | (ID_EX_Rt_addr == IF_ID_Rt_addr));
    assign halted   = (state == HALTED);

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        flush_event   = 1'b0;
        state_next    = state;
        if (rst) begin
            state_next = RUN;
        end else if (freeze) begin
            // freeze outranks everything, including a halt decoded this cycle
            PC_Write      = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
            if (state != HALTED) state_next = MEM_WAIT;
        end else if (state == HALTED) begin
            PC_Write    = 1'b0;
            IF_ID_flush = 1'b1;
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            state_next   = RUN;
        end else if (halt_req) begin
            state_next = HALTED;
        end else begin
            if (branch_taken) begin
                IF_ID_flush = 1'b1;
                flush_event = 1'b1;
            end
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_next;
            if (!freeze) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (freeze && (wait_cnt + CNT_W'(1)) == WAIT_LIMIT) mem_timeout <= 1'b1;
            if (!PC_Write && state != HALTED && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_W'(1);
            if (flush_event && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stall_controller.sv
// Bench for pipe_stall_controller: directed scenarios plus randomized traffic
// against a rule-level reference model.
module tb_pipe_stall_controller;
    localparam int TB_MAX_WAIT = 4;
    localparam int TB_CNT_W    = 4;
    localparam int CMAX        = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, ld, br, hreq, mreq, rdy;
    logic [4:0] ex_rt, rs, rt;
    logic PC_Write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble;
    logic [TB_CNT_W-1:0] stall_count, flush_count;
    logic mem_timeout, halted;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_stall, m_flush, m_run;
    bit m_timeout, m_halted;

    pipe_stall_controller #(.MAX_WAIT(TB_MAX_WAIT), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_MemRead(ld), .ID_EX_Rt_addr(ex_rt),
        .IF_ID_Rs_addr(rs), .IF_ID_Rt_addr(rt),
        .branch_taken(br), .halt_req(hreq),
        .EX_MEM_mem_req(mreq), .dmem_ready(rdy),
        .PC_Write(PC_Write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_bubble(MEM_WB_bubble),
        .stall_count(stall_count), .flush_count(flush_count),
        .mem_timeout(mem_timeout), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl_now();
        return {PC_Write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble};
    endfunction

    function automatic bit is_freeze();
        return mreq && !rdy;
    endfunction

    function automatic bit is_load_use();
        return ld && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
    endfunction

    // {PC_Write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, MEM_WB_bubble}
    function automatic logic [6:0] model_ctrl();
        if (rst)           return 7'b1101010;
        if (is_freeze())   return 7'b0000001;
        if (m_halted)      return 7'b0111010;
        if (is_load_use()) return 7'b0001110;
        if (hreq)          return 7'b1101010;
        if (br)            return 7'b1111010;
        return 7'b1101010;
    endfunction

    // advance the model by one clock using the inputs present now, then clock the DUT
    task automatic step();
        logic [6:0] c;
        bit fr, lu;
        c  = model_ctrl();
        fr = is_freeze();
        lu = is_load_use();
        if (rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_timeout = 0; m_halted = 0;
        end else begin
            if (fr) begin
                if (m_run < TB_MAX_WAIT) m_run++;
                if (m_run == TB_MAX_WAIT) m_timeout = 1;
            end else begin
                m_run = 0;
            end
            if (!c[6] && !m_halted && m_stall < CMAX) m_stall++;
            if (br && !fr && !m_halted && !lu && !hreq && m_flush < CMAX) m_flush++;
            if (!m_halted && !fr && !lu && hreq) m_halted = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; ld = 0; br = 0; hreq = 0; mreq = 0; rdy = 0;
        ex_rt = 0; rs = 0; rt = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; ld = 1; ex_rt = 3; rs = 3; mreq = 1; br = 1;
        #1;
        n_checks++;
        if (ctrl_now() !== 7'b1101010) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl_now(), 7'b1101010);
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if ({stall_count, flush_count, mem_timeout, halted} !== '0) begin
            n_fail++; $display("FAIL reset_regs: stall %0d flush %0d tmo %b halted %b want all 0",
                               stall_count, flush_count, mem_timeout, halted);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ld = 1; ex_rt = 8; rs = 8; rt = 2;
        #1;
        n_checks++;
        if ({PC_Write, IF_ID_write, ID_EX_bubble} !== 3'b001) begin
            n_fail++; $display("FAIL load_use_ctrl: got PC/IFw/bub %b want 001", {PC_Write, IF_ID_write, ID_EX_bubble});
        end
        step();
        ld = 0;
        #1;
        n_checks++;
        if (stall_count !== 4'd1) begin
            n_fail++; $display("FAIL load_use_count: got %0d want 1", stall_count);
        end
        ld = 1; ex_rt = 0; rs = 0; rt = 0;
        #1;
        n_checks++;
        if ({PC_Write, IF_ID_write, ID_EX_bubble} !== 3'b110) begin
            n_fail++; $display("FAIL load_use_r0: got PC/IFw/bub %b want 110", {PC_Write, IF_ID_write, ID_EX_bubble});
        end
        step();
        ld = 0;
        #1;
        n_checks++;
        if (stall_count !== 4'd1) begin
            n_fail++; $display("FAIL load_use_r0_count: got %0d want 1", stall_count);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mreq = 1; rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({EX_MEM_write, MEM_WB_bubble, PC_Write} !== 3'b010) begin
                n_fail++; $display("FAIL mem_wait_freeze%0d: got EXw/MWbub/PC %b want 010", i, {EX_MEM_write, MEM_WB_bubble, PC_Write});
            end
            step();
        end
        rdy = 1;
        #1;
        n_checks++;
        if (ctrl_now() !== 7'b1101010) begin
            n_fail++; $display("FAIL mem_wait_release: got %b want 1101010", ctrl_now());
        end
        step();
        clear_inputs();
        #1;
        n_checks++;
        if (stall_count !== 4'd3 || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_count: stall %0d tmo %b want 3 0", stall_count, mem_timeout);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mreq = 1; rdy = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (mem_timeout !== (i >= 3)) begin
                n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", i + 2, mem_timeout, (i >= 3));
            end
        end
        rdy = 1;
        step();
        clear_inputs();
        step();
        n_checks++;
        if (mem_timeout !== 1'b1 || stall_count !== 4'd6) begin
            n_fail++; $display("FAIL timeout_sticky: tmo %b stall %0d want 1 6", mem_timeout, stall_count);
        end
        do_reset();
        n_checks++;
        if (mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear: got %b want 0", mem_timeout);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ld = 1; ex_rt = 5; rt = 5; rs = 1; br = 1;
        #1;
        n_checks++;
        if ({IF_ID_flush, ID_EX_bubble, PC_Write} !== 3'b010) begin
            n_fail++; $display("FAIL prio_lu_br: got flush/bub/PC %b want 010", {IF_ID_flush, ID_EX_bubble, PC_Write});
        end
        step();
        br = 0; mreq = 1; rdy = 0;
        #1;
        n_checks++;
        if (ctrl_now() !== 7'b0000001) begin
            n_fail++; $display("FAIL prio_freeze_lu: got %b want 0000001", ctrl_now());
        end
        hreq = 1;
        step();
        clear_inputs();
        #1;
        n_checks++;
        if ({flush_count, stall_count, halted} !== {4'd0, 4'd2, 1'b0}) begin
            n_fail++; $display("FAIL prio_counts: flush %0d stall %0d halted %b want 0 2 0", flush_count, stall_count, halted);
        end
    endtask

    task automatic test_branch_sat();
        do_reset();
        br = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (IF_ID_flush !== 1'b1 || PC_Write !== 1'b1) begin
                n_fail++; $display("FAIL branch_flush%0d: flush %b PC %b want 1 1", i, IF_ID_flush, PC_Write);
            end
            step();
            if (i == 2) begin
                n_checks++;
                if (flush_count !== 4'd3) begin
                    n_fail++; $display("FAIL branch_count3: got %0d want 3", flush_count);
                end
            end
        end
        n_checks++;
        if (flush_count !== 4'd15) begin
            n_fail++; $display("FAIL branch_saturate: got %0d want 15", flush_count);
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        logic [TB_CNT_W-1:0] held;
        do_reset();
        ld = 1; ex_rt = 7; rs = 7;
        step();
        ld = 0; hreq = 1;
        #1;
        n_checks++;
        if (ctrl_now() !== 7'b1101010) begin
            n_fail++; $display("FAIL halt_req_cycle: got %b want 1101010", ctrl_now());
        end
        step();
        hreq = 0;
        held = stall_count;
        n_checks++;
        if (halted !== 1'b1 || PC_Write !== 1'b0 || IF_ID_flush !== 1'b1) begin
            n_fail++; $display("FAIL halt_state: halted %b PC %b flush %b want 1 0 1", halted, PC_Write, IF_ID_flush);
        end
        br = 1; ld = 1; ex_rt = 3; rs = 3;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (stall_count !== 4'd1 || flush_count !== 4'd0 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_frozen: stall %0d flush %0d halted %b want 1 0 1", stall_count, flush_count, halted);
        end
        do_reset();
        n_checks++;
        if ({halted, stall_count, flush_count, PC_Write} !== {1'b0, 4'd0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL halt_reset: halted %b stall %0d flush %0d PC %b want 0 0 0 1",
                               halted, stall_count, flush_count, PC_Write);
        end
        if (held !== 4'd1) begin
            n_checks++; n_fail++; $display("FAIL halt_entry_count: got %0d want 1", held);
        end else begin
            n_checks++;
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            ld    = $urandom_range(0, 1);
            ex_rt = 5'($urandom_range(0, 3));
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            br    = ($urandom_range(0, 2) == 0);
            hreq  = ($urandom_range(0, 39) == 0);
            mreq  = $urandom_range(0, 1);
            rdy   = ($urandom_range(0, 2) != 0);
            #1;
            e = model_ctrl();
            n_checks++;
            if (ctrl_now() !== e) begin
                n_fail++; $display("FAIL rand_ctrl@%0d: got %b want %b", i, ctrl_now(), e);
            end
            step();
            n_checks++;
            if (stall_count !== TB_CNT_W'(m_stall) || flush_count !== TB_CNT_W'(m_flush) ||
                mem_timeout !== m_timeout || halted !== m_halted) begin
                n_fail++; $display("FAIL rand_regs@%0d: stall %0d/%0d flush %0d/%0d tmo %b/%b halted %b/%b (got/want)",
                                   i, stall_count, m_stall, flush_count, m_flush, mem_timeout, m_timeout, halted, m_halted);
            end
        end
        clear_inputs();
    endtask

    initial begin
        m_stall = 0; m_flush = 0; m_run = 0; m_timeout = 0; m_halted = 0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_branch_sat();
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stall_controller.md
# pipe_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It handles three things: load-use hazards between ID/EX and IF/ID, multi-cycle data-memory accesses signalled by a ready handshake, and taken-branch flushes resolved in ID. It drives the write enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and keeps saturating stall/flush performance counters, a memory-timeout flag and a halt state.

## Interface
Parameters:
- MAX_WAIT, 16: consecutive memory-freeze cycles that set mem_timeout (range 1 to 2^CNT_W-1).
- CNT_W, 16: width of the wait counter and the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_Rt_addr  in  5  load destination register.
- IF_ID_Rs_addr  in  5  Rs of the instruction in ID.
- IF_ID_Rt_addr  in  5  Rt of the instruction in ID.
- branch_taken  in  1  branch/jump resolved taken in ID this cycle.
- halt_req  in  1  halt instruction decoded in ID.
- EX_MEM_mem_req  in  1  the MEM stage holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  IF/ID loads a NOP.
- ID_EX_write  out  1  ID/EX load enable.
- ID_EX_bubble  out  1  ID/EX control fields loaded as zero.
- EX_MEM_write  out  1  EX/MEM load enable.
- MEM_WB_bubble  out  1  MEM/WB control fields loaded as zero.
- stall_count  out  CNT_W  cycles with PC_Write=0 while not HALTED; saturating.
- flush_count  out  CNT_W  branch flush cycles; saturating.
- mem_timeout  out  1  sticky; set after MAX_WAIT consecutive freeze cycles.
- halted  out  1  state is HALTED.

## Operation
Derived signals:
- freeze = EX_MEM_mem_req & ~dmem_ready.
- load_use = ID_EX_MemRead & (ID_EX_Rt_addr != 0) & (ID_EX_Rt_addr == IF_ID_Rs_addr | ID_EX_Rt_addr == IF_ID_Rt_addr).

States: RUN, MEM_WAIT, HALTED.

Default control outputs: all *_write = 1, all flush/bubble = 0.

Control outputs are combinational from state and inputs. Rules apply in priority order; the first match wins:
1. **rst = 1:** defaults.
2. **freeze:** PC_Write = IF_ID_write = ID_EX_write = EX_MEM_write = 0; MEM_WB_bubble = 1. Applies in any state.
3. **HALTED:** PC_Write = 0, IF_ID_flush = 1, so the pipeline drains with NOPs.
4. **load_use:** PC_Write = 0, IF_ID_write = 0, ID_EX_bubble = 1. Any branch_taken or halt_req this cycle is ignored; the instruction re-presents next cycle.
5. **halt_req:** defaults this cycle; next state is HALTED.
6. **branch_taken:** IF_ID_flush = 1.
7. Otherwise defaults.

Transitions:
- RUN → MEM_WAIT on freeze.
- MEM_WAIT → RUN on the first cycle freeze = 0. This covers dmem_ready = 1 or the request being withdrawn.
- RUN or MEM_WAIT → HALTED when rule 5 fires.
- HALTED exits only on rst.
- A halt_req arriving during freeze is ignored.

Counters (registered; all cleared by rst):
- **wait_cnt:** increments on each freeze cycle, clears when freeze = 0, saturates at MAX_WAIT.
- **mem_timeout:** set on the edge where wait_cnt reaches MAX_WAIT; stays set until rst. The FSM keeps waiting.
- **stall_count:** +1 on each cycle where PC_Write = 0 and state != HALTED; holds at all-ones.
- **flush_count:** +1 on each cycle where rule 6 fires; holds at all-ones.

## Timing
- Reset values: state RUN; stall_count = 0, flush_count = 0, wait_cnt = 0; mem_timeout = 0; halted = 0. Control outputs are at defaults while rst is high.
- Stall and flush controls have zero latency: they act in the cycle the condition is present.
- A load-use stall lasts exactly one cycle per hazard, because the bubble clears ID_EX_MemRead.
- Memory freeze lasts N cycles when dmem_ready rises N cycles after EX_MEM_mem_req. The release cycle has defaults (or lower-priority rules).
- Counter, halted and mem_timeout updates are visible one cycle after the qualifying cycle.
- rst asserted mid-freeze or in HALTED returns to RUN on the next edge; counters and flag clear.

## Test plan
- **Load-use hazard:** ID_EX_MemRead = 1, Rt = 8, IF_ID Rs = 8 for one cycle.
  - Required: PC_Write = 0, IF_ID_write = 0, ID_EX_bubble = 1 that cycle; stall_count = 1 next cycle.
  - Repeat with Rt = 0: no stall.
- **Memory wait:** EX_MEM_mem_req = 1, dmem_ready held low 3 cycles then high.
  - Required: 3 freeze cycles (EX_MEM_write = 0, MEM_WB_bubble = 1); state MEM_WAIT, then RUN; stall_count = 3.
- **Timeout:** MAX_WAIT = 4, dmem_ready low 6 cycles.
  - Required: mem_timeout = 1 from cycle 5 onward and still 1 after release; cleared only by rst.
- **Priority:** load_use and branch_taken together → stall only, flush_count unchanged. Then freeze together with load_use → freeze controls, ID_EX_bubble = 0.
- **Branch flush and saturation:** branch_taken for 3 cycles → IF_ID_flush = 1 each cycle, flush_count = 3. With CNT_W = 4, 20 flush cycles → flush_count holds at 15.
- **Halt and reset:** halt_req in RUN → halted = 1 next cycle, PC_Write = 0, IF_ID_flush = 1 and stall_count frozen. rst pulse → RUN, all counters 0.
